// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with guard blanking,
// leading-zero suppression, per-digit blink and decimal points.
module ssd_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 16,
  parameter int unsigned BLINK_DIV   = 250
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [4*DIGITS-1:0]                            value,
  input  logic [DIGITS-1:0]                              dp,
  input  logic                                           load,
  input  logic                                           lz_en,
  input  logic [DIGITS-1:0]                              blink_en,
  input  logic                                           enable,
  output logic [6:0]                                     seg,
  output logic                                           dp_n,
  output logic [DIGITS-1:0]                              an,
  output logic [$clog2((DIGITS > 1) ? DIGITS : 2)-1:0]  digit_idx,
  output logic                                           scan_tick
);

  localparam int unsigned IW = $clog2((DIGITS > 1) ? DIGITS : 2);
  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned VW = 4 * DIGITS;

  logic [VW-1:0]     sh_value;
  logic [DIGITS-1:0] sh_dp;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;

  logic              cnt_wrap;
  logic              idx_wrap;
  logic              blink_wrap;
  logic              all_zero;
  logic [DIGITS-1:0] lz_zero;
  logic [DIGITS-1:0] an_sel;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blink;
  logic              cur_lz;
  logic              dark;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Current-digit selection and the blanking decision feeding the output registers.
  always_comb begin
    cnt_wrap   = (cnt == CW'(REFRESH_DIV - 1));
    idx_wrap   = (digit_idx == IW'(DIGITS - 1));
    blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));
    all_zero   = 1'b1;
    lz_zero    = '0;
    an_sel     = '1;
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    cur_lz     = 1'b0;
    // A digit is suppressible when it and every more-significant nibble are zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero & (sh_value[4*i +: 4] == 4'h0);
      lz_zero[i] = all_zero & (i != 0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        cur_nib   = sh_value[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_blink = blink_en[i];
        cur_lz    = lz_zero[i];
        an_sel[i] = 1'b0;
      end
    end
    dark = (cnt < CW'(GUARD)) | (cur_blink & blink_phase) | (lz_en & cur_lz);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_value    <= '0;
      sh_dp       <= '0;
      cnt         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      digit_idx   <= '0;
      scan_tick   <= 1'b0;
      an          <= '1;
      seg         <= 7'b1111111;
      dp_n        <= 1'b1;
    end else begin
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp;
      end
      scan_tick <= 1'b0;
      if (enable) begin
        if (cnt_wrap) begin
          cnt       <= '0;
          digit_idx <= idx_wrap ? '0 : digit_idx + IW'(1);
          scan_tick <= 1'b1;
          if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (!enable || dark) begin
        an   <= '1;
        seg  <= 7'b1111111;
        dp_n <= 1'b1;
      end else begin
        an   <= an_sel;
        seg  <= decode(cur_nib);
        dp_n <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with DIGITS=4, REFRESH_DIV=8, GUARD=2, BLINK_DIV=2.
module tb_ssd_scan_driver;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned REFRESH_DIV = 8;
  localparam int unsigned GUARD       = 2;
  localparam int unsigned BLINK_DIV   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  blink_en = '0;
  logic        enable = 1'b1;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        scan_tick;

  int          checks = 0;
  int          fails = 0;
  int unsigned m = 0;

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [6:0] seg_tbl [4];
  logic [3:0] lit_mask = 4'hF;
  logic [3:0] blink_mask = 4'h0;
  logic [3:0] dp_mask = 4'h0;

  ssd_scan_driver #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .GUARD(GUARD), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .lz_en(lz_en),
    .blink_en(blink_en), .enable(enable), .seg(seg), .dp_n(dp_n), .an(an),
    .digit_idx(digit_idx), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  // m counts enabled edges since reset; the display model is indexed by it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) m = 0;
    else if (enable) m++;
  endtask

  // Expected {an, seg, dp_n} after the latest enabled edge.
  function automatic logic [11:0] expect_out();
    int unsigned s, d, ph;
    logic lit;
    logic [3:0] one;
    s   = (m - 1) / REFRESH_DIV;
    d   = s % DIGITS;
    ph  = (m - 1) % REFRESH_DIV;
    lit = (ph >= GUARD) && lit_mask[d] && !(blink_mask[d] && ((s / BLINK_DIV) % 2 == 1));
    one = 4'b0001 << d;
    if (!lit) return {4'hF, 7'h7F, 1'b1};
    return {~one, seg_tbl[d], ~dp_mask[d]};
  endfunction

  task automatic load_value(input logic [15:0] v, input logic [3:0] p);
    value = v;
    dp    = p;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({an, seg, dp_n} !== {4'hF, 7'h7F, 1'b1}) begin
      $display("FAIL reset_out got an=%b seg=%b dp_n=%b want 1111 1111111 1", an, seg, dp_n);
      fails++;
    end
    checks++;
    if ({digit_idx, scan_tick} !== 3'b000) begin
      $display("FAIL reset_idx got idx=%0d tick=%b want 0 0", digit_idx, scan_tick);
      fails++;
    end
    seg_tbl = '{glyph[0], glyph[0], glyph[0], glyph[0]};
    lit_mask = 4'hF; blink_mask = 4'h0; dp_mask = 4'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      e = expect_out();
      checks++;
      if ({an, seg, dp_n} !== e) begin
        $display("FAIL reset_scan m=%0d got %b %b %b want %b %b %b", m, an, seg, dp_n, e[11:8], e[7:1], e[0]);
        fails++;
      end
    end
  endtask

  task automatic test_scan();
    logic [11:0] e;
    load_value(16'h12AF, 4'h0);
    seg_tbl = '{glyph[15], glyph[10], glyph[2], glyph[1]};
    lit_mask = 4'hF; dp_mask = 4'h0;
    for (int i = 0; i < 64; i++) begin
      tick();
      e = expect_out();
      checks++;
      if ({an, seg, dp_n} !== e) begin
        $display("FAIL scan m=%0d got %b %b %b want %b %b %b", m, an, seg, dp_n, e[11:8], e[7:1], e[0]);
        fails++;
      end
      checks++;
      if (scan_tick !== (m % REFRESH_DIV == 0)) begin
        $display("FAIL scan_tick m=%0d got %b", m, scan_tick);
        fails++;
      end
      checks++;
      if (digit_idx !== 2'((m / REFRESH_DIV) % DIGITS)) begin
        $display("FAIL digit_idx m=%0d got %0d want %0d", m, digit_idx, (m / REFRESH_DIV) % DIGITS);
        fails++;
      end
    end
  endtask

  task automatic test_lz();
    logic [11:0] e;
    load_value(16'h0050, 4'h0);
    seg_tbl = '{glyph[0], glyph[5], glyph[0], glyph[0]};
    for (int pass = 0; pass < 2; pass++) begin
      lz_en    = (pass == 0);
      lit_mask = (pass == 0) ? 4'b0011 : 4'b1111;
      for (int i = 0; i < 32; i++) begin
        tick();
        e = expect_out();
        checks++;
        if ({an, seg, dp_n} !== e) begin
          $display("FAIL lz%0d m=%0d got %b %b %b want %b %b %b", pass, m, an, seg, dp_n, e[11:8], e[7:1], e[0]);
          fails++;
        end
      end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_all_zero();
    logic [11:0] e;
    load_value(16'h0000, 4'h0);
    lz_en = 1'b1;
    lit_mask = 4'b0001;
    seg_tbl = '{glyph[0], glyph[0], glyph[0], glyph[0]};
    for (int i = 0; i < 32; i++) begin
      tick();
      e = expect_out();
      checks++;
      if ({an, seg, dp_n} !== e) begin
        $display("FAIL all_zero m=%0d got %b %b %b want %b %b %b", m, an, seg, dp_n, e[11:8], e[7:1], e[0]);
        fails++;
      end
    end
    lz_en = 1'b0;
    lit_mask = 4'hF;
  endtask

  task automatic test_dp();
    logic [11:0] e;
    load_value(16'h12AF, 4'b0100);
    seg_tbl = '{glyph[15], glyph[10], glyph[2], glyph[1]};
    dp_mask = 4'b0100;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = expect_out();
      checks++;
      if ({an, seg, dp_n} !== e) begin
        $display("FAIL dp m=%0d got %b %b %b want %b %b %b", m, an, seg, dp_n, e[11:8], e[7:1], e[0]);
        fails++;
      end
    end
  endtask

  task automatic test_blink();
    logic [11:0] e;
    load_value(16'h12AF, 4'h0);
    dp_mask = 4'h0;
    for (int pass = 0; pass < 2; pass++) begin
      blink_en   = (pass == 0) ? 4'b0001 : 4'b1111;
      blink_mask = blink_en;
      for (int i = 0; i < 64; i++) begin
        tick();
        e = expect_out();
        checks++;
        if ({an, seg, dp_n} !== e) begin
          $display("FAIL blink%0d m=%0d got %b %b %b want %b %b %b", pass, m, an, seg, dp_n, e[11:8], e[7:1], e[0]);
          fails++;
        end
      end
    end
    blink_en = 4'h0;
    blink_mask = 4'h0;
  endtask

  task automatic test_enable();
    logic [11:0] e;
    logic [1:0]  idx;
    for (int i = 0; i < 8 && (m % REFRESH_DIV) != 4; i++) tick();
    idx = 2'((m / REFRESH_DIV) % DIGITS);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({an, seg, dp_n, scan_tick, digit_idx} !== {4'hF, 7'h7F, 1'b1, 1'b0, idx}) begin
        $display("FAIL enable_off i=%0d got an=%b seg=%b dp_n=%b tick=%b idx=%0d want idx=%0d", i, an, seg, dp_n, scan_tick, digit_idx, idx);
        fails++;
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      e = expect_out();
      checks++;
      if ({an, seg, dp_n} !== e) begin
        $display("FAIL enable_resume m=%0d got %b %b %b want %b %b %b", m, an, seg, dp_n, e[11:8], e[7:1], e[0]);
        fails++;
      end
      checks++;
      if ({scan_tick, digit_idx} !== {(m % REFRESH_DIV == 0), 2'((m / REFRESH_DIV) % DIGITS)}) begin
        $display("FAIL enable_count m=%0d got tick=%b idx=%0d", m, scan_tick, digit_idx);
        fails++;
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [11:0] e;
    for (int i = 0; i < 40 && !(((m / REFRESH_DIV) % DIGITS == 2) && (m % REFRESH_DIV == 4)); i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({an, seg, dp_n, scan_tick, digit_idx} !== {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0}) begin
      $display("FAIL rst_mid got an=%b seg=%b dp_n=%b tick=%b idx=%0d", an, seg, dp_n, scan_tick, digit_idx);
      fails++;
    end
    seg_tbl = '{glyph[0], glyph[0], glyph[0], glyph[0]};
    dp_mask = 4'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      e = expect_out();
      checks++;
      if ({an, seg, dp_n} !== e) begin
        $display("FAIL rst_restart m=%0d got %b %b %b want %b %b %b", m, an, seg, dp_n, e[11:8], e[7:1], e[0]);
        fails++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    logic [3:0]  nib;
    logic [3:0]  prev;
    prev = 4'h0;
    load = 1'b1;
    for (int i = 0; i < 40; i++) begin
      nib   = 4'(i % 16);
      value = {4{nib}};
      tick();
      seg_tbl = '{glyph[prev], glyph[prev], glyph[prev], glyph[prev]};
      e = expect_out();
      checks++;
      if ({an, seg, dp_n} !== e) begin
        $display("FAIL load_track m=%0d got %b %b %b want %b %b %b", m, an, seg, dp_n, e[11:8], e[7:1], e[0]);
        fails++;
      end
      prev = nib;
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_all_zero();
    test_dp();
    test_blink();
    test_enable();
    test_rst_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
